serial_adder_ctrl: RTL



---
 rtl/serial_adder_ctrl_pkg.sv | 21 ++
 rtl/serial_adder_ctrl_fulladder.sv | 24 ++
 rtl/serial_adder_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// ============================================================================
// Module   : serial_adder_ctrl_pkg
// Brief    : Shared state encodings and default sizes for the serial adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_adder_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_ctrl_fulladder.sv
// ============================================================================
// Module   : fulladder
// Brief    : Gate-level 1-bit full adder cell.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fulladder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign sum   = w_axb ^ c_in;
    assign c_out = (a & b) | (c_in & w_axb);

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module   : serial_adder_ctrl
// Brief    : Bit-serial WIDTH-bit adder sequencing one full adder cell, LSB first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   sa_q;
    logic [WIDTH-1:0]   sb_q;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_d;
    logic               c_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;
    logic               ovf_q;

    logic               w_sum;
    logic               w_cout;

    fulladder u_fa (
        .a     (sa_q[0]),
        .b     (sb_q[0]),
        .c_in  (c_q),
        .sum   (w_sum),
        .c_out (w_cout)
    );

    // Partial sum accumulates separately so the published result holds until the next done.
    assign sum_d = {w_sum, sum_q[WIDTH-1:1]};
    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sum_q    <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= op_a;
                        sb_q    <= op_b;
                        c_q     <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    c_q   <= w_cout;
                    sum_q <= sum_d;
                    cnt_q <= cnt_d;
                    if (cnt_q == C_LAST_BIT) begin
                        result_q <= sum_d;
                        cout_q   <= w_cout;
                        ovf_q    <= c_q ^ w_cout;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

`default_nettype wire
